// File: rtl/instruction_fetch.sv
// Instruction fetch stage: reads IMEM at the current PC over a REQ/ACK
// handshake, holds the returned word in IR, decodes the fixed BETA fields
// and stalls the PC stage until the instruction is consumed or redirected.
module instruction_fetch #(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] PC,
  input  logic        ADVANCE,
  input  logic        FLUSH,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_ACK,
  input  logic [31:0] IMEM_RDATA,
  output logic [31:0] IR,
  output logic [31:0] IR_PC,
  output logic        IR_VALID,
  output logic [5:0]  OPCODE,
  output logic [4:0]  RC,
  output logic [4:0]  RA,
  output logic [4:0]  RB,
  output logic [15:0] ID,
  output logic        PC_STALL,
  output logic        FETCH_ERR
);

  localparam int            CW       = $clog2(TIMEOUT + 1);
  // Abort on the edge that closes the TIMEOUT-th waiting cycle.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_DRAIN} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          req_n, vld_n, err_n;
  logic [31:0]   addr_n, ir_n, irpc_n;
  logic [31:0]   fetch_addr;
  logic          timed_out;
  logic          unused_pc_bits;

  // Supervisor bit never reaches memory; byte offset is dropped.
  assign fetch_addr     = {1'b0, PC[30:2], 2'b00};
  assign timed_out      = (cnt == CNT_LAST);
  assign unused_pc_bits = ^PC[1:0];

  // Next-state and next-register values; everything holds by default.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    req_n   = IMEM_REQ;
    addr_n  = IMEM_ADDR;
    ir_n    = IR;
    irpc_n  = IR_PC;
    vld_n   = IR_VALID;
    err_n   = 1'b0;
    case (state)
      S_IDLE: begin
        // PC is stable here (previous consume/redirect already landed).
        state_n = S_REQ;
        req_n   = 1'b1;
        addr_n  = fetch_addr;
        cnt_n   = '0;
      end
      S_REQ: begin
        if (IMEM_ACK && !FLUSH) begin
          ir_n    = IMEM_RDATA;
          irpc_n  = PC;
          vld_n   = 1'b1;
          req_n   = 1'b0;
          cnt_n   = '0;
          state_n = S_HOLD;
        end else if (IMEM_ACK) begin
          // Data belongs to the abandoned path; reissue at the redirect PC.
          addr_n = fetch_addr;
          cnt_n  = '0;
        end else if (FLUSH) begin
          // Request still outstanding; must swallow its ACK before refetching.
          cnt_n   = '0;
          state_n = S_DRAIN;
        end else if (timed_out) begin
          err_n   = 1'b1;
          req_n   = 1'b0;
          cnt_n   = '0;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_HOLD: begin
        // Detour through IDLE so the refetch sees the updated PC.
        if (ADVANCE || FLUSH) begin
          vld_n   = 1'b0;
          state_n = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (IMEM_ACK) begin
          req_n   = 1'b0;
          cnt_n   = '0;
          state_n = S_IDLE;
        end else if (timed_out) begin
          err_n   = 1'b1;
          req_n   = 1'b0;
          cnt_n   = '0;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= S_IDLE;
      cnt       <= '0;
      IMEM_REQ  <= 1'b0;
      IMEM_ADDR <= '0;
      IR        <= '0;
      IR_PC     <= '0;
      IR_VALID  <= 1'b0;
      FETCH_ERR <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      IMEM_REQ  <= req_n;
      IMEM_ADDR <= addr_n;
      IR        <= ir_n;
      IR_PC     <= irpc_n;
      IR_VALID  <= vld_n;
      FETCH_ERR <= err_n;
    end
  end

  // Field decode follows IR regardless of IR_VALID.
  assign OPCODE = IR[31:26];
  assign RC     = IR[25:21];
  assign RA     = IR[20:16];
  assign RB     = IR[15:11];
  assign ID     = IR[15:0];

  // PC moves only on consume or redirect; frozen while in reset.
  assign PC_STALL = !RESET || !(((state == S_HOLD) && ADVANCE) || FLUSH);

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: table of fetch/decode vectors, directed
// flush/timeout/reset sequences, then random traffic against a program-order
// model of the instruction stream.
module tb_instruction_fetch;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        RESET, ADVANCE, FLUSH, IMEM_ACK;
  logic [31:0] PC, IMEM_RDATA;
  logic        IMEM_REQ, IR_VALID, PC_STALL, FETCH_ERR;
  logic [31:0] IMEM_ADDR, IR, IR_PC;
  logic [5:0]  OPCODE;
  logic [4:0]  RC, RA, RB;
  logic [15:0] ID;

  always #5 CLK = ~CLK;

  instruction_fetch #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET(RESET), .PC(PC), .ADVANCE(ADVANCE), .FLUSH(FLUSH),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_ACK(IMEM_ACK),
    .IMEM_RDATA(IMEM_RDATA), .IR(IR), .IR_PC(IR_PC), .IR_VALID(IR_VALID),
    .OPCODE(OPCODE), .RC(RC), .RA(RA), .RB(RB), .ID(ID),
    .PC_STALL(PC_STALL), .FETCH_ERR(FETCH_ERR)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [5:0]  op;
    logic [4:0]  rc;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [15:0] id;
  } vec_t;

  vec_t vt[5];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] waddr(input logic [31:0] p);
    return {1'b0, p[30:2], 2'b00};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Bounded wait for a request; returns at a negedge.
  task automatic wait_req();
    int k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (!IMEM_REQ && k < 20);
    chk1("req_seen", IMEM_REQ, 1'b1);
  endtask

  task automatic ack_word(input logic [31:0] w);
    IMEM_ACK = 1'b1;
    IMEM_RDATA = w;
    @(negedge CLK);
    IMEM_ACK = 1'b0;
    IMEM_RDATA = 32'h0;
    ADVANCE = 1'b0;
  endtask

  // Called at a negedge in HOLD: consume IR, then present the next PC.
  task automatic consume(input logic [31:0] next_pc);
    ADVANCE = 1'b1;
    #1 chk1("stall_adv", PC_STALL, 1'b0);
    @(negedge CLK);
    ADVANCE = 1'b0;
    PC = next_pc;
    #1;
    chk1("valid_drop", IR_VALID, 1'b0);
    chk1("stall_idle", PC_STALL, 1'b1);
  endtask

  initial begin
    logic [31:0] pc_reg, pc_next, exp_pc, target;
    logic        prev_req, prev_af;
    logic [31:0] prev_addr;
    int          wc, n_acc;

    vt[0] = '{32'h80000000, 32'hC07F0010, 32'h00000000, 6'h30, 5'd3,  5'd31, 5'd0,  16'h0010};
    vt[1] = '{32'h0000123F, 32'hFFFFFFFF, 32'h0000123C, 6'h3F, 5'd31, 5'd31, 5'd31, 16'hFFFF};
    vt[2] = '{32'hFFFFFFFC, 32'h00000000, 32'h7FFFFFFC, 6'h00, 5'd0,  5'd0,  5'd0,  16'h0000};
    vt[3] = '{32'h7FFFFFFF, 32'h8421F800, 32'h7FFFFFFC, 6'h21, 5'd1,  5'd1,  5'd31, 16'hF800};
    vt[4] = '{32'h80000A0C, 32'h7BE0FFFE, 32'h00000A0C, 6'h1E, 5'd31, 5'd0,  5'd31, 16'hFFFE};

    // Reset state, with FLUSH high to show the stall is forced.
    RESET = 1'b0; ADVANCE = 1'b0; FLUSH = 1'b1; IMEM_ACK = 1'b0;
    IMEM_RDATA = 32'h0; PC = vt[0].pc;
    repeat (2) @(negedge CLK);
    #1;
    chk1("rst_req", IMEM_REQ, 1'b0);
    chk("rst_addr", IMEM_ADDR, 32'h0);
    chk("rst_ir", IR, 32'h0);
    chk("rst_irpc", IR_PC, 32'h0);
    chk1("rst_valid", IR_VALID, 1'b0);
    chk1("rst_err", FETCH_ERR, 1'b0);
    chk1("rst_stall", PC_STALL, 1'b1);
    @(negedge CLK);
    FLUSH = 1'b0;
    RESET = 1'b1;

    // Table: fetch, decode, hold with stray ACK, consume.
    for (int i = 0; i < 5; i++) begin
      wait_req();
      chk("addr", IMEM_ADDR, vt[i].addr);
      ADVANCE = 1'b1;  // no valid IR yet: must be ignored
      #1 chk1("stall_req", PC_STALL, 1'b1);
      ack_word(vt[i].rdata);
      chk1("valid", IR_VALID, 1'b1);
      chk("ir", IR, vt[i].rdata);
      chk("ir_pc", IR_PC, vt[i].pc);
      chk("opcode", 32'(OPCODE), 32'(vt[i].op));
      chk("rc", 32'(RC), 32'(vt[i].rc));
      chk("ra", 32'(RA), 32'(vt[i].ra));
      chk("rb", 32'(RB), 32'(vt[i].rb));
      chk("id", 32'(ID), 32'(vt[i].id));
      chk1("req_drop", IMEM_REQ, 1'b0);
      IMEM_ACK = 1'b1;
      IMEM_RDATA = 32'hDEADBEEF;
      @(negedge CLK);
      IMEM_ACK = 1'b0;
      #1;
      chk("ir_hold", IR, vt[i].rdata);
      chk1("valid_hold", IR_VALID, 1'b1);
      chk1("stall_hold", PC_STALL, 1'b1);
      consume(i < 4 ? vt[i+1].pc : 32'h00000100);
    end

    // FLUSH with request outstanding, ACK three cycles later.
    wait_req();
    chk("addr_a", IMEM_ADDR, 32'h00000100);
    FLUSH = 1'b1;
    PC = 32'h80000200;
    #1 chk1("stall_flush", PC_STALL, 1'b0);
    @(negedge CLK);
    FLUSH = 1'b0;
    chk1("req_drain", IMEM_REQ, 1'b1);
    chk1("valid_drain", IR_VALID, 1'b0);
    repeat (2) @(negedge CLK);
    IMEM_ACK = 1'b1;
    IMEM_RDATA = 32'hBADBAD00;
    @(negedge CLK);
    IMEM_ACK = 1'b0;
    chk1("req_drained", IMEM_REQ, 1'b0);
    chk1("valid_drained", IR_VALID, 1'b0);
    chk("ir_drained", IR, vt[4].rdata);
    wait_req();
    chk("addr_redirect", IMEM_ADDR, 32'h00000200);
    ack_word(32'h11112222);
    chk("ir_a", IR, 32'h11112222);
    chk("ir_pc_a", IR_PC, 32'h80000200);
    consume(32'h00000300);

    // ACK and FLUSH in the same cycle.
    wait_req();
    chk("addr_b", IMEM_ADDR, 32'h00000300);
    IMEM_ACK = 1'b1; IMEM_RDATA = 32'h55555555;
    FLUSH = 1'b1; PC = 32'h00000400;
    @(negedge CLK);
    IMEM_ACK = 1'b0; FLUSH = 1'b0;
    chk1("valid_b", IR_VALID, 1'b0);
    chk("ir_b", IR, 32'h11112222);
    chk1("req_b", IMEM_REQ, 1'b1);
    chk("readdr_b", IMEM_ADDR, 32'h00000400);
    ack_word(32'h66666666);
    chk("ir_b2", IR, 32'h66666666);
    chk("ir_pc_b2", IR_PC, 32'h00000400);
    consume(32'h80000500);

    // Timeout with no ACK: four waiting cycles, one-cycle error, retry.
    wait_req();
    chk("addr_c", IMEM_ADDR, 32'h00000500);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk1("err_wait", FETCH_ERR, 1'b0);
      chk1("req_wait", IMEM_REQ, 1'b1);
    end
    @(negedge CLK);
    chk1("err_pulse", FETCH_ERR, 1'b1);
    chk1("req_abort", IMEM_REQ, 1'b0);
    @(negedge CLK);
    chk1("err_clear", FETCH_ERR, 1'b0);
    chk1("req_retry", IMEM_REQ, 1'b1);
    chk("addr_retry", IMEM_ADDR, 32'h00000500);

    // Reset mid-REQ, between clock edges.
    #2 RESET = 1'b0;
    #1;
    chk1("rreq_req", IMEM_REQ, 1'b0);
    chk("rreq_addr", IMEM_ADDR, 32'h0);
    chk1("rreq_stall", PC_STALL, 1'b1);
    @(negedge CLK);
    RESET = 1'b1;
    PC = 32'h00000600;
    wait_req();
    chk("addr_d", IMEM_ADDR, 32'h00000600);
    ack_word(32'h77777777);
    chk1("valid_d", IR_VALID, 1'b1);
    // Reset in HOLD.
    ADVANCE = 1'b1;
    #2 RESET = 1'b0;
    #1;
    chk1("rhold_valid", IR_VALID, 1'b0);
    chk("rhold_ir", IR, 32'h0);
    chk("rhold_irpc", IR_PC, 32'h0);
    chk1("rhold_stall", PC_STALL, 1'b1);
    @(negedge CLK);
    ADVANCE = 1'b0;
    RESET = 1'b1;
    PC = 32'h00000700;
    wait_req();
    chk("addr_restart", IMEM_ADDR, 32'h00000700);

    // Random traffic against a program-order model.
    @(negedge CLK);
    RESET = 1'b0;
    PC = 32'h80000000;
    @(negedge CLK);
    RESET = 1'b1;
    pc_reg = PC; pc_next = PC; exp_pc = PC;
    prev_req = 1'b0; prev_af = 1'b0; prev_addr = 32'h0;
    wc = 0; n_acc = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      pc_reg = pc_next;
      if (prev_req && IMEM_REQ && !prev_af)
        chk("addr_stable", IMEM_ADDR, prev_addr);
      chk("addr_form", IMEM_ADDR & 32'h80000003, 32'h0);
      chk1("no_err", FETCH_ERR, 1'b0);
      IMEM_ACK = 1'b0;
      if (IMEM_REQ) begin
        if (wc == 0) begin
          IMEM_ACK = 1'b1;
          IMEM_RDATA = memf(IMEM_ADDR);
          wc = $urandom_range(0, 2);
        end else begin
          wc--;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        IMEM_ACK = 1'b1;
        IMEM_RDATA = $urandom;
      end
      FLUSH = ($urandom_range(0, 9) == 0);
      ADVANCE = $urandom_range(0, 1) == 1;
      target = $urandom;
      PC = FLUSH ? target : pc_reg;
      #1;
      chk1("stall_rule", PC_STALL, !((IR_VALID && ADVANCE) || FLUSH));
      chk("fields", {11'h0, OPCODE, RC, RA, RB}, {11'h0, IR[31:11]});
      chk("id_field", 32'(ID), {16'h0, IR[15:0]});
      if (IR_VALID && ADVANCE && !FLUSH) begin
        chk("seq_pc", IR_PC, exp_pc);
        chk("seq_word", IR, memf(waddr(IR_PC)));
        exp_pc = exp_pc + 32'd4;
        n_acc++;
      end
      if (FLUSH) exp_pc = target;
      pc_next = FLUSH ? target : ((IR_VALID && ADVANCE) ? pc_reg + 32'd4 : pc_reg);
      prev_req = IMEM_REQ;
      prev_addr = IMEM_ADDR;
      prev_af = IMEM_ACK && FLUSH;
    end
    chk1("progress", n_acc > 50, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Sits directly downstream of the program counter stage.
- Takes the current PC, issues a read to instruction memory over a REQ/ACK handshake, and holds the returned word in the instruction register (IR).
- Decodes the fixed BETA fields (opcode, RC, RA, RB, 16-bit literal), which feed control and the PC stage's ID input.
- Drives PC_STALL so the PC advances exactly once per instruction accepted downstream.

Parameters:
TIMEOUT, 255, max cycles to wait for IMEM_ACK before aborting the fetch; counter width = clog2(TIMEOUT+1)

Ports:
CLK  input  1  system clock, all state on rising edge
RESET  input  1  asynchronous, active-low reset
PC  input  32  current PC; bit 31 = supervisor bit
ADVANCE  input  1  downstream consumes IR this cycle
FLUSH  input  1  discard IR and any in-flight fetch (branch/trap redirect)
IMEM_REQ  output  1  read request to instruction memory
IMEM_ADDR  output  32  word address {1'b0, PC[30:2], 2'b00}, registered
IMEM_ACK  input  1  memory returns data this cycle
IMEM_RDATA  input  32  instruction word, valid when IMEM_ACK=1
IR  output  32  registered instruction
IR_PC  output  32  PC (including bit 31) of the instruction in IR
IR_VALID  output  1  IR holds an unconsumed instruction
OPCODE  output  6  IR[31:26]
RC  output  5  IR[25:21]
RA  output  5  IR[20:16]
RB  output  5  IR[15:11]
ID  output  16  IR[15:0], to the PC stage ID input
PC_STALL  output  1  1 = PC stage must hold its value this edge
FETCH_ERR  output  1  one-cycle pulse on fetch timeout

Behaviour:
Reset
- RESET low forces, asynchronously: state=IDLE, IR=0, IR_PC=0, IR_VALID=0, IMEM_REQ=0, IMEM_ADDR=0, FETCH_ERR=0, timeout counter=0.
- PC_STALL=1 while RESET is low.
- Reset mid-handshake aborts the fetch; the memory tolerates a dropped REQ.

States: IDLE, REQ, HOLD, DRAIN. Transitions:
- IDLE: one cycle after reset release -> REQ. On the entry edge, IMEM_ADDR <= {1'b0, PC[30:2], 2'b00}, IMEM_REQ <= 1.
- REQ, IMEM_ACK=1, FLUSH=0: IR <= IMEM_RDATA, IR_PC <= PC, IR_VALID <= 1, IMEM_REQ <= 0 -> HOLD. Latency: IR_VALID rises on the edge after the ACK cycle.
- REQ, IMEM_ACK=1, FLUSH=1: data discarded; re-register IMEM_ADDR from the (now updated) PC, keep IMEM_REQ=1, stay in REQ.
- REQ, IMEM_ACK=0, FLUSH=1: request already in flight; IMEM_REQ held -> DRAIN.
- REQ, no ACK: increment counter. When counter reaches TIMEOUT: FETCH_ERR=1 for one cycle, IMEM_REQ <= 0, counter <= 0 -> IDLE (automatic retry).
- HOLD, ADVANCE=1 or FLUSH=1: IR_VALID <= 0; -> REQ, registering the new PC into IMEM_ADDR on the next edge.
  - The transition goes HOLD -> IDLE-equivalent single cycle -> REQ, so the fetch uses the updated PC.
  - Minimum spacing: one instruction every 3 cycles with single-cycle ACK.
- HOLD, neither ADVANCE nor FLUSH: hold IR/IR_VALID.
- DRAIN: wait for IMEM_ACK; discard data, IMEM_REQ <= 0 -> IDLE. Timeout applies as in REQ (FETCH_ERR pulse, -> IDLE).

PC_STALL (combinational) = ~((state==HOLD & ADVANCE) | FLUSH). The PC stage updates only on the edge where an instruction is consumed or a redirect occurs.

Boundary rules
- ADVANCE with IR_VALID=0 is ignored.
- ADVANCE and FLUSH together: same as FLUSH; the PC advances once.
- IMEM_ACK outside REQ/DRAIN is ignored.
- IMEM_ADDR is stable while IMEM_REQ=1.
- Counter clears on every REQ/DRAIN entry.
- Decoded field outputs follow IR combinationally, including while IR_VALID=0.
- Bit 31 of PC is never driven onto IMEM_ADDR but is preserved in IR_PC.

Test Plan:
- Reset release, PC=0x80000000, ACK one cycle after REQ, RDATA=0xC07F0010 -> IMEM_ADDR=0x00000000; IR_VALID=1 with IR=0xC07F0010, OPCODE=0x30, RC=3, RA=31, ID=0x0010, IR_PC=0x80000000; PC_STALL=1 until ADVANCE.
- ADVANCE pulse in HOLD, PC moves 0x80000000->0x80000004 -> PC_STALL=0 for exactly that cycle; IR_VALID=0 next edge; new REQ with IMEM_ADDR=0x00000004.
- FLUSH asserted while REQ is outstanding, ACK 3 cycles later -> DRAIN; returned word never reaches IR; IR_VALID stays 0; next REQ uses the redirected PC.
- ACK and FLUSH in the same cycle -> IR unchanged; REQ stays high; IMEM_ADDR re-registers from the new PC.
- TIMEOUT=4, ACK never asserted -> FETCH_ERR pulses once after 4 waiting cycles; REQ drops for one cycle, then retries at the same address.
- RESET asserted low in HOLD and in REQ -> all outputs return to reset values immediately, without a clock edge; after release the fetch restarts from IDLE.
